// File: rtl/cdc_req_ack_ctrl.sv
// Source-side four-phase req/ack controller: holds a captured word on xfer_data,
// sequences xfer_req against the synchronized ack, counts transfers and flags stalls.
module cdc_req_ack_ctrl #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] xfer_data,
    output logic             xfer_req,
    input  logic             ack_sync,
    input  logic             err_clr,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] xfer_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Timer only has to reach TIMEOUT-1 before the FSM leaves for ERR.
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = (TIMEOUT == 0) ? {TW{1'b0}} : TW'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               timed_out_s;

    // A stale high ack from the previous handshake blocks a new acceptance.
    assign in_ready    = (state_q == IDLE) && !ack_sync;
    assign busy        = (state_q != IDLE);
    assign xfer_req    = (state_q == REQ);
    assign timeout_err = (state_q == ERR);
    assign xfer_data   = data_q;
    assign xfer_count  = count_q;
    assign timed_out_s = (TIMEOUT != 0) && (timer_q == T_LAST);

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= {TW{1'b0}};
            data_q  <= {WIDTH{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    // Next-state logic; an exit condition always takes priority over the timeout
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        data_d  = data_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_d  = in_data;
                    timer_d = {TW{1'b0}};
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (ack_sync) begin
                    timer_d = {TW{1'b0}};
                    state_d = DROP;
                end else if (timed_out_s) begin
                    state_d = ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DROP: begin
                if (!ack_sync) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = IDLE;
                end else if (timed_out_s) begin
                    state_d = ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ERR: begin
                if (err_clr && !ack_sync) begin
                    state_d = IDLE;
                end else begin
                    state_d = ERR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cdc_req_ack_ctrl.sv
// Directed bench for cdc_req_ack_ctrl: main instance (TIMEOUT=8) plus a CNT_W=2
// instance on the same stimulus for counter wrap.
module tb_cdc_req_ack_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        ack_sync;
    logic        err_clr;

    logic        in_ready, xfer_req, busy, timeout_err;
    logic [7:0]  xfer_data;
    logic [15:0] xfer_count;

    logic        w_in_ready, w_xfer_req, w_busy, w_timeout_err;
    logic [7:0]  w_xfer_data;
    logic [1:0]  w_xfer_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cdc_req_ack_ctrl #(.WIDTH(8), .TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .xfer_data(xfer_data), .xfer_req(xfer_req),
        .ack_sync(ack_sync), .err_clr(err_clr), .busy(busy),
        .timeout_err(timeout_err), .xfer_count(xfer_count)
    );

    cdc_req_ack_ctrl #(.WIDTH(8), .TIMEOUT(8), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(w_in_ready), .xfer_data(w_xfer_data), .xfer_req(w_xfer_req),
        .ack_sync(ack_sync), .err_clr(err_clr), .busy(w_busy),
        .timeout_err(w_timeout_err), .xfer_count(w_xfer_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; ack_sync = 1'b0; err_clr = 1'b0;
        step();
        step();
        chk("rst_xfer_req", {31'd0, xfer_req}, 32'd0);
        chk("rst_xfer_data", {24'd0, xfer_data}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {16'd0, xfer_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        // Basic transfer of 0xA5 with slow ack edges
        in_valid = 1'b1; in_data = 8'hA5;
        step();
        chk("basic_data", {24'd0, xfer_data}, 32'hA5);
        chk("basic_req", {31'd0, xfer_req}, 32'd1);
        chk("basic_busy", {31'd0, busy}, 32'd1);
        chk("basic_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0; in_data = 8'hFF;
        step(); step(); step();
        chk("basic_req_held", {31'd0, xfer_req}, 32'd1);
        ack_sync = 1'b1;
        step();
        chk("basic_req_drop", {31'd0, xfer_req}, 32'd0);
        chk("basic_drop_busy", {31'd0, busy}, 32'd1);
        step(); step(); step();
        ack_sync = 1'b0;
        step();
        chk("basic_count", {16'd0, xfer_count}, 32'd1);
        chk("basic_in_ready_back", {31'd0, in_ready}, 32'd1);
        chk("basic_busy_idle", {31'd0, busy}, 32'd0);
        chk("basic_data_hold", {24'd0, xfer_data}, 32'hA5);

        // Back-to-back with immediate-echo ack: one accept every 3 cycles
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 8'(i);
            step();
            chk("b2b_data", {24'd0, xfer_data}, 32'(i));
            chk("b2b_req", {31'd0, xfer_req}, 32'd1);
            ack_sync = 1'b1; in_data = 8'hEE;
            step();
            chk("b2b_req_drop", {31'd0, xfer_req}, 32'd0);
            chk("b2b_data_stable", {24'd0, xfer_data}, 32'(i));
            ack_sync = 1'b0;
            step();
            chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
            chk("b2b_count", {16'd0, xfer_count}, 32'(i + 1));
        end
        in_valid = 1'b0;
        chk("wrap_count_5", {30'd0, w_xfer_count}, 32'd1);

        // Stale ack in IDLE blocks acceptance
        ack_sync = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        #1;
        chk("stale_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("stale_no_capture", {24'd0, xfer_data}, 32'h04);
        chk("stale_not_busy", {31'd0, busy}, 32'd0);
        step();
        ack_sync = 1'b0;
        #1;
        chk("stale_ready_after", {31'd0, in_ready}, 32'd1);
        step();
        chk("stale_capture", {24'd0, xfer_data}, 32'h5A);
        chk("stale_req", {31'd0, xfer_req}, 32'd1);
        in_valid = 1'b0; ack_sync = 1'b1;
        step();
        ack_sync = 1'b0;
        step();
        chk("stale_count", {16'd0, xfer_count}, 32'd6);

        // Timeout: no ack for 8 REQ cycles
        in_valid = 1'b1; in_data = 8'hC3;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("to_req_7", {31'd0, xfer_req}, 32'd1);
        chk("to_err_7", {31'd0, timeout_err}, 32'd0);
        step();
        chk("to_err_8", {31'd0, timeout_err}, 32'd1);
        chk("to_req_low", {31'd0, xfer_req}, 32'd0);
        chk("to_busy", {31'd0, busy}, 32'd1);
        ack_sync = 1'b1; err_clr = 1'b1;
        step();
        chk("to_clr_ack_high", {31'd0, timeout_err}, 32'd1);
        ack_sync = 1'b0; err_clr = 1'b0;
        step();
        chk("to_sticky", {31'd0, timeout_err}, 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("to_cleared", {31'd0, timeout_err}, 32'd0);
        chk("to_idle", {31'd0, busy}, 32'd0);
        chk("to_count", {16'd0, xfer_count}, 32'd6);
        chk("to_data_hold", {24'd0, xfer_data}, 32'hC3);

        // Ack on the 8th REQ cycle wins over the timeout
        in_valid = 1'b1; in_data = 8'h3C;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        ack_sync = 1'b1;
        step();
        chk("tie_no_err", {31'd0, timeout_err}, 32'd0);
        chk("tie_drop_req", {31'd0, xfer_req}, 32'd0);
        chk("tie_busy", {31'd0, busy}, 32'd1);
        ack_sync = 1'b0;
        step();
        chk("tie_count", {16'd0, xfer_count}, 32'd7);
        chk("wrap_count_7", {30'd0, w_xfer_count}, 32'd3);
        chk("wrap_data", {24'd0, w_xfer_data}, 32'h3C);

        // Reset in the middle of REQ
        in_valid = 1'b1; in_data = 8'h99;
        step();
        in_valid = 1'b0;
        chk("mid_req", {31'd0, xfer_req}, 32'd1);
        chk("mid_req_wrap", {31'd0, w_xfer_req}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_req", {31'd0, xfer_req}, 32'd0);
        chk("mid_rst_data", {24'd0, xfer_data}, 32'd0);
        chk("mid_rst_count", {16'd0, xfer_count}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_err", {31'd0, timeout_err}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_wrap", {28'd0, w_in_ready, w_busy, w_timeout_err, w_xfer_req}, 32'h8);
        chk("mid_rst_wrap_cnt", {30'd0, w_xfer_count}, 32'd0);
        step();
        chk("post_rst_req", {31'd0, xfer_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdc_req_ack_ctrl.md
# cdc_req_ack_ctrl

Source-side controller for a four-phase req/ack handshake that carries a WIDTH-bit word across a clock-domain boundary through the team's two-flop `cdc_synchronizer`. It accepts a word from local logic, holds it stable on `xfer_data`, raises `xfer_req` (synchronized into the receive domain), and sequences the handshake against `ack_sync`, the receiver's ack already brought back through a `cdc_synchronizer` into this block's domain. It also counts completed transfers and flags a stalled handshake with a timeout.

## Interface
- WIDTH, 8, data word width
- TIMEOUT, 255, max cycles spent waiting in REQ or DROP; 0 disables the timeout
- CNT_W, 16, width of completed-transfer counter

Ports:
- clk  in  1  block clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  local word offered
- in_data  in  WIDTH  local word
- in_ready  out  1  block can accept a word this cycle
- xfer_data  out  WIDTH  held word toward receive domain
- xfer_req  out  1  request level, fed to `cdc_synchronizer` into receive domain
- ack_sync  in  1  receiver ack, already synchronized into clk domain
- err_clr  in  1  clears timeout error (single-cycle pulse)
- busy  out  1  handshake in progress (state != IDLE)
- timeout_err  out  1  sticky timeout flag
- xfer_count  out  CNT_W  completed transfers, wraps modulo 2^CNT_W

## Operation
- Registered FSM, states IDLE, REQ, DROP, ERR. All outputs are registers or decodes of state only; no input reaches an output combinationally except `in_ready`, which uses `ack_sync`.
- Reset values: state IDLE, `xfer_req`=0, `xfer_data`=0, `timeout_err`=0, `xfer_count`=0, wait timer=0, `busy`=0.
- `in_ready` = (state==IDLE) & !`ack_sync`. A stale high ack blocks acceptance.
- IDLE: on `in_valid & in_ready`, capture `in_data` into `xfer_data`, go to REQ. Otherwise stay.
- REQ: `xfer_req`=1. When `ack_sync`=1, go to DROP.
- DROP: `xfer_req`=0. When `ack_sync`=0, go to IDLE and increment `xfer_count`.
- ERR: `xfer_req`=0, `timeout_err`=1. Go to IDLE only on a cycle with `err_clr`=1 and `ack_sync`=0. `err_clr` in any other state is ignored.
- Timeout:
  - Wait timer clears on entry to REQ and on entry to DROP.
  - It increments each cycle spent in REQ or DROP.
  - If TIMEOUT != 0, timer == TIMEOUT-1, and the exit condition is not met that cycle, the next state is ERR.
  - If the ack condition and timeout occur in the same cycle, the ack wins.
- `xfer_data` changes only on capture in IDLE. It holds its value through REQ, DROP, ERR and afterwards, so it is stable whenever `xfer_req` is high or its receiver-side echo may still be high.
- `in_data` is ignored outside the accepting cycle.
- Reset mid-handshake: `xfer_req` drops to 0 on the next edge and the FSM returns to IDLE. The receiver tolerates this because acceptance waits for `ack_sync`=0.

## Timing
- Accept at edge N (`in_valid & in_ready` sampled): `xfer_data` = word and `xfer_req`=1 from N+1. `in_ready`=0 and `busy`=1 from N+1.
- `ack_sync` sampled 1 at edge M: `xfer_req`=0 from M+1.
- `ack_sync` sampled 0 at edge K in DROP: IDLE, `xfer_count`+1 and `in_ready`=1 (if ack still low) from K+1.
- Minimum turnaround is 3 cycles from accept to the next possible accept, reached when ack rises and falls on consecutive cycles.
- Timeout: at most TIMEOUT cycles are spent in REQ (or in DROP). `timeout_err` asserts on the edge ending the TIMEOUT-th waiting cycle.
- `timeout_err` clears on the edge that leaves ERR.

## Test plan
- Basic transfer: reset, offer 0xA5, ack high 4 cycles after `xfer_req` rises, low 4 cycles after `xfer_req` falls. Expect `xfer_data`=0xA5 and `xfer_req`=1 one cycle after accept, `xfer_count`=1, `in_ready` back to 1, `xfer_data` still 0xA5.
- Back-to-back: `in_valid` held with words 0x01..0x04 and an immediate-echo ack (1 cycle each). Expect 4 transfers, 3-cycle spacing between accepts, `xfer_count`=4, each word stable while `xfer_req`=1.
- Stale ack: `ack_sync`=1 in IDLE with `in_valid`=1. Expect `in_ready`=0 and no capture until ack falls, then accept next cycle.
- Timeout: TIMEOUT=8, never ack. Expect ERR after 8 REQ cycles, `timeout_err`=1, `xfer_req`=0, `err_clr` ignored while ack high, IDLE after `err_clr` with ack low, `xfer_count` unchanged.
- Ack-vs-timeout tie: TIMEOUT=8, ack rises on the 8th REQ cycle. Expect DROP, no error.
- Reset mid-REQ and counter wrap: assert `rst` in REQ; expect all outputs at reset values next cycle. Separately with CNT_W=2, complete 5 transfers; expect `xfer_count`=1.
